// File: rtl/mac_tx_frame_scheduler_if.sv
// Request/descriptor bus between NUM_REQ requesters plus the MAC frame
// generator on one side and the frame scheduler on the other.
// master: requesters/generator side. slave: the scheduler.
interface mac_tx_frame_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ*48-1:0] i_req_dest;
  logic [NUM_REQ*16-1:0] i_req_eth_type;
  logic [NUM_REQ*16-1:0] i_req_length;
  logic [NUM_REQ*8-1:0]  i_req_mode;
  logic                  i_tx_valid;
  logic                  o_start;
  logic [47:0]           o_dest_address;
  logic [47:0]           o_src_address;
  logic [15:0]           o_eth_type;
  logic [15:0]           o_payload_length;
  logic [7:0]            o_interrupt;
  logic [NUM_REQ-1:0]    o_grant;
  logic [NUM_REQ-1:0]    o_done;
  logic [NUM_REQ-1:0]    o_err;
  logic                  o_busy;

  modport master (
    output i_req, i_req_dest, i_req_eth_type, i_req_length, i_req_mode, i_tx_valid,
    input  o_start, o_dest_address, o_src_address, o_eth_type, o_payload_length,
           o_interrupt, o_grant, o_done, o_err, o_busy
  );

  modport slave (
    input  i_req, i_req_dest, i_req_eth_type, i_req_length, i_req_mode, i_tx_valid,
    output o_start, o_dest_address, o_src_address, o_eth_type, o_payload_length,
           o_interrupt, o_grant, o_done, o_err, o_busy
  );
endinterface

// File: rtl/mac_tx_frame_scheduler.sv
// Frame scheduler in front of the MAC/MII frame generator.
// Arbitrates NUM_REQ requesters, latches the winner's descriptor, drives
// the generator start, tracks the frame via i_tx_valid, then enforces the
// inter-frame gap. Bad lengths and start timeouts give per-requester errors.
// Optional: define SCHED_STRICT_PRIO_EN for lowest-index-wins arbitration
// instead of round-robin.

// Per-requester length legality check.
module mac_tx_sched_lane #(
  parameter int PAYLOAD_MAX_SIZE = 1500
) (
  input  logic [15:0] len,
  output logic        len_ok
);
  assign len_ok = (len != 16'd0) && (len <= 16'(PAYLOAD_MAX_SIZE));
endmodule

module mac_tx_frame_scheduler #(
  parameter int          NUM_REQ          = 4,
  parameter int          PAYLOAD_MAX_SIZE = 1500,
  parameter int          IPG_CYCLES       = 12,
  parameter int          START_TIMEOUT    = 64,
  parameter logic [47:0] SRC_ADDRESS      = 48'h123456789ABC
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  mac_tx_frame_scheduler_if.slave  bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW   = $clog2(START_TIMEOUT + 1);
  localparam int IW   = $clog2(IPG_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, ARB, START, TX, IPG} state_t;

  state_t                    state;
  logic [IDXW-1:0]           cur;
  logic [TW-1:0]             tcnt;
  logic [IW-1:0]             icnt;
  logic                      tx_prev;
  logic [IDXW-1:0]           win;
  logic [IDXW-1:0]           idx;
  logic [NUM_REQ-1:0]        len_ok;

  logic [NUM_REQ-1:0][47:0]  dest_a;
  logic [NUM_REQ-1:0][15:0]  type_a;
  logic [NUM_REQ-1:0][15:0]  len_a;
  logic [NUM_REQ-1:0][7:0]   mode_a;

  assign dest_a = bus.i_req_dest;
  assign type_a = bus.i_req_eth_type;
  assign len_a  = bus.i_req_length;
  assign mode_a = bus.i_req_mode;

  assign bus.o_src_address = SRC_ADDRESS;

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_lane
    mac_tx_sched_lane #(.PAYLOAD_MAX_SIZE(PAYLOAD_MAX_SIZE)) u_lane (
      .len    (len_a[g]),
      .len_ok (len_ok[g])
    );
  end

`ifdef SCHED_STRICT_PRIO_EN
  // Winner select: lowest-index active request.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDXW'(i);
      if (bus.i_req[idx]) win = idx;
    end
  end
`else
  logic [IDXW-1:0] ptr;

  // Winner select: first active request after the last winner, wrapping.
  // Scanned farthest-first so the nearest candidate overwrites.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDXW'((int'(ptr) + i) % NUM_REQ);
      if (bus.i_req[idx]) win = idx;
    end
  end

  // Round-robin pointer follows every arbitration winner, including rejects.
  always_ff @(posedge clk) begin
    if (!i_rst_n)
      ptr <= IDXW'(NUM_REQ - 1);
    else if (state == ARB && |bus.i_req)
      ptr <= win;
  end
`endif

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      cur                  <= '0;
      tcnt                 <= '0;
      icnt                 <= '0;
      tx_prev              <= 1'b0;
      bus.o_start          <= 1'b0;
      bus.o_dest_address   <= '0;
      bus.o_eth_type       <= '0;
      bus.o_payload_length <= '0;
      bus.o_interrupt      <= '0;
      bus.o_grant          <= '0;
      bus.o_done           <= '0;
      bus.o_err            <= '0;
      bus.o_busy           <= 1'b0;
    end else begin
      tx_prev     <= bus.i_tx_valid;
      bus.o_grant <= '0;
      bus.o_done  <= '0;
      bus.o_err   <= '0;
      case (state)
        IDLE: begin
          if (|bus.i_req) begin
            state      <= ARB;
            bus.o_busy <= 1'b1;
          end
        end
        ARB: begin
          if (!(|bus.i_req)) begin
            // requester withdrew before arbitration completed
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end else if (!len_ok[win]) begin
            // descriptor outputs deliberately left untouched on reject
            bus.o_err  <= ONE << win;
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end else begin
            cur                  <= win;
            bus.o_grant          <= ONE << win;
            bus.o_dest_address   <= dest_a[win];
            bus.o_eth_type       <= type_a[win];
            bus.o_payload_length <= len_a[win];
            bus.o_interrupt      <= mode_a[win];
            bus.o_start          <= 1'b1;
            tcnt                 <= '0;
            state                <= START;
          end
        end
        START: begin
          if (bus.i_tx_valid) begin
            bus.o_start <= 1'b0;
            state       <= TX;
          end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
            // generator never responded: o_start has been high START_TIMEOUT clocks
            bus.o_start <= 1'b0;
            bus.o_err   <= ONE << cur;
            icnt        <= '0;
            state       <= IPG;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        TX: begin
          if (tx_prev && !bus.i_tx_valid) begin
            bus.o_done <= ONE << cur;
            icnt       <= '0;
            state      <= IPG;
          end
        end
        IPG: begin
          if (icnt == IW'(IPG_CYCLES - 1)) begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end else begin
            icnt <= icnt + IW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          bus.o_start <= 1'b0;
          bus.o_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_frame_scheduler.sv
// Directed bench for mac_tx_frame_scheduler (NUM_REQ=4, defaults elsewhere).
// Outputs are sampled 1ns after each rising edge; inputs change there too.
module tb_mac_tx_frame_scheduler;
  localparam logic [47:0] SRC = 48'h123456789ABC;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mac_tx_frame_scheduler_if #(.NUM_REQ(4)) bus ();

  mac_tx_frame_scheduler #(
    .NUM_REQ(4), .PAYLOAD_MAX_SIZE(1500), .IPG_CYCLES(12),
    .START_TIMEOUT(64), .SRC_ADDRESS(SRC)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int k, input logic [47:0] d, input logic [15:0] t,
                          input logic [15:0] l, input logic [7:0] m);
    bus.i_req_dest[k*48 +: 48]     = d;
    bus.i_req_eth_type[k*16 +: 16] = t;
    bus.i_req_length[k*16 +: 16]   = l;
    bus.i_req_mode[k*8 +: 8]       = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req = '0; bus.i_tx_valid = 1'b0;
    bus.i_req_dest = '0; bus.i_req_eth_type = '0; bus.i_req_length = '0; bus.i_req_mode = '0;
    repeat (3) tick();
    n_chk++; if (bus.o_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0h want 0", bus.o_start); end
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.o_busy); end
    n_chk++; if ({bus.o_grant, bus.o_done, bus.o_err} !== 12'h0) begin n_fail++; $display("FAIL reset_pulses: got %0h want 0", {bus.o_grant, bus.o_done, bus.o_err}); end
    n_chk++; if ({bus.o_dest_address, bus.o_eth_type, bus.o_payload_length, bus.o_interrupt} !== '0) begin n_fail++; $display("FAIL reset_desc: got %0h want 0", {bus.o_dest_address, bus.o_eth_type, bus.o_payload_length, bus.o_interrupt}); end
    n_chk++; if (bus.o_src_address !== SRC) begin n_fail++; $display("FAIL reset_src: got %0h want %0h", bus.o_src_address, SRC); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0h want 0", bus.o_busy); end
  endtask

  task automatic test_rr();
    int  done_cnt;
    bit  found;
    logic [3:0] exp;
    for (int k = 0; k < 4; k++) set_desc(k, 48'h0200_0000_0000 + 48'(k), 16'h0800, 16'd8, 8'd0);
    bus.i_req = 4'b1111;
    done_cnt = 0;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
        tick();
        if (bus.o_done != 4'b0) done_cnt++;
        if (bus.o_grant != 4'b0) found = 1'b1;
      end
      exp = 4'b0001 << (g % 4);
      n_chk++; if (!found || bus.o_grant !== exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, bus.o_grant, exp); end
      if (g > 0) begin
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL rr_done%0d: got %0d want 1", g, done_cnt); end
      end
      done_cnt = 0;
      tick(); bus.i_tx_valid = 1'b1;
      repeat (3) tick();
      bus.i_tx_valid = 1'b0;
    end
    bus.i_req = 4'b0;
    for (int t = 0; t < 40 && bus.o_busy; t++) begin
      tick();
      if (bus.o_done != 4'b0) done_cnt++;
    end
    n_chk++; if (done_cnt != 1 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rr_last_done: got %0d busy %0h want 1 busy 0", done_cnt, bus.o_busy); end
  endtask

`ifdef SCHED_STRICT_PRIO_EN
  task automatic test_strict();
    bit found;
    set_desc(0, 48'h0A0A_0A0A_0A0A, 16'h0800, 16'd8, 8'd2);
    set_desc(3, 48'h0B0B_0B0B_0B0B, 16'h0800, 16'd8, 8'd0);
    bus.i_req = 4'b1001;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
        tick();
        if (bus.o_grant != 4'b0) found = 1'b1;
      end
      n_chk++; if (!found || bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL strict_grant%0d: got %b want 0001", g, bus.o_grant); end
      n_chk++; if (bus.o_interrupt !== 8'd2) begin n_fail++; $display("FAIL strict_mode%0d: got %0d want 2", g, bus.o_interrupt); end
      if (g == 2) bus.i_req = 4'b1000;
      tick(); bus.i_tx_valid = 1'b1;
      repeat (3) tick();
      bus.i_tx_valid = 1'b0;
    end
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    n_chk++; if (!found || bus.o_grant !== 4'b1000) begin n_fail++; $display("FAIL strict_req3: got %b want 1000", bus.o_grant); end
    bus.i_req = 4'b0;
    tick(); bus.i_tx_valid = 1'b1;
    repeat (3) tick();
    bus.i_tx_valid = 1'b0;
    for (int t = 0; t < 40 && bus.o_busy; t++) tick();
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL strict_idle: got %0h want 0", bus.o_busy); end
  endtask
`endif

  task automatic test_single();
    bit found;
    bit bad_done;
    bit done_seen;
    int gap;
    set_desc(1, 48'hA1A2_A3A4_A5A6, 16'h0800, 16'd49, 8'd0);
    bus.i_req = 4'b0010;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    n_chk++; if (!found || bus.o_grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b want 0010", bus.o_grant); end
    n_chk++; if ({bus.o_dest_address, bus.o_eth_type, bus.o_payload_length, bus.o_interrupt} !== {48'hA1A2_A3A4_A5A6, 16'h0800, 16'd49, 8'd0}) begin
      n_fail++; $display("FAIL single_desc: got %0h %0h %0d %0d", bus.o_dest_address, bus.o_eth_type, bus.o_payload_length, bus.o_interrupt); end
    n_chk++; if (bus.o_start !== 1'b1 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL single_start0: got start %0h busy %0h want 1 1", bus.o_start, bus.o_busy); end
    bus.i_req = 4'b0;
    set_desc(1, 48'hFFFF_0000_FFFF, 16'h86DD, 16'd7, 8'd9);
    tick();
    n_chk++; if (bus.o_start !== 1'b1) begin n_fail++; $display("FAIL single_start1: got %0h want 1", bus.o_start); end
    tick();
    n_chk++; if (bus.o_start !== 1'b1) begin n_fail++; $display("FAIL single_start2: got %0h want 1", bus.o_start); end
    bus.i_tx_valid = 1'b1;
    tick();
    n_chk++; if (bus.o_start !== 1'b0) begin n_fail++; $display("FAIL single_start3: got %0h want 0", bus.o_start); end
    bad_done = 1'b0;
    repeat (9) begin
      tick();
      if (bus.o_done != 4'b0) bad_done = 1'b1;
    end
    n_chk++; if (bad_done) begin n_fail++; $display("FAIL single_early_done: got 1 want 0"); end
    bus.i_tx_valid = 1'b0;
    tick();
    n_chk++; if (bus.o_done !== 4'b0010) begin n_fail++; $display("FAIL single_done: got %b want 0010", bus.o_done); end
    n_chk++; if ({bus.o_dest_address, bus.o_payload_length} !== {48'hA1A2_A3A4_A5A6, 16'd49}) begin n_fail++; $display("FAIL single_desc_hold: got %0h %0d", bus.o_dest_address, bus.o_payload_length); end
    set_desc(1, 48'hA1A2_A3A4_A5A6, 16'h0800, 16'd49, 8'd0);
    bus.i_req = 4'b0010;
    gap = 0; found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      tick(); gap++;
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    n_chk++; if (!found || gap < 12) begin n_fail++; $display("FAIL single_ipg: got gap %0d found %0d want >=12", gap, found); end
    bus.i_req = 4'b0;
    tick(); bus.i_tx_valid = 1'b1;
    tick(); tick();
    bus.i_tx_valid = 1'b0;
    done_seen = 1'b0;
    for (int t = 0; t < 30 && bus.o_busy; t++) begin
      tick();
      if (bus.o_done == 4'b0010) done_seen = 1'b1;
    end
    n_chk++; if (!done_seen || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_second: got done %0d busy %0h", done_seen, bus.o_busy); end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens [2];
    bit found;
    bit start_seen;
    bit done_seen;
    lens[0] = 16'd0; lens[1] = 16'd1501;
    for (int j = 0; j < 2; j++) begin
      set_desc(2, 48'hBAD0_BAD0_BAD0, 16'h0800, lens[j], 8'd0);
      bus.i_req = 4'b0100;
      found = 1'b0; start_seen = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
        tick();
        if (bus.o_start) start_seen = 1'b1;
        if (bus.o_err != 4'b0) found = 1'b1;
      end
      bus.i_req = 4'b0;
      n_chk++; if (!found || bus.o_err !== 4'b0100 || bus.o_grant !== 4'b0) begin n_fail++; $display("FAIL bad_len%0d_err: got err %b grant %b want 0100 0000", j, bus.o_err, bus.o_grant); end
      n_chk++; if (bus.o_payload_length !== 16'd49) begin n_fail++; $display("FAIL bad_len%0d_hold: got %0d want 49", j, bus.o_payload_length); end
      repeat (3) begin
        tick();
        if (bus.o_start) start_seen = 1'b1;
      end
      n_chk++; if (start_seen || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL bad_len%0d_start: got start %0d busy %0h want 0 0", j, start_seen, bus.o_busy); end
    end
    set_desc(3, 48'h3333_3333_3333, 16'h86DD, 16'd1500, 8'd1);
    bus.i_req = 4'b1000;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    bus.i_req = 4'b0;
    n_chk++; if (!found || bus.o_grant !== 4'b1000 || bus.o_payload_length !== 16'd1500) begin n_fail++; $display("FAIL max_len_grant: got %b len %0d want 1000 1500", bus.o_grant, bus.o_payload_length); end
    tick(); bus.i_tx_valid = 1'b1;
    tick(); tick();
    bus.i_tx_valid = 1'b0;
    done_seen = 1'b0;
    for (int t = 0; t < 30 && bus.o_busy; t++) begin
      tick();
      if (bus.o_done == 4'b1000) done_seen = 1'b1;
    end
    n_chk++; if (!done_seen || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL max_len_done: got done %0d busy %0h", done_seen, bus.o_busy); end
  endtask

  task automatic test_timeout();
    bit found;
    int hi;
    int idle_t;
    set_desc(0, 48'h0000_0000_0001, 16'h0800, 16'd8, 8'd0);
    bus.i_req = 4'b0001;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    bus.i_req = 4'b0;
    n_chk++; if (!found || bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL to_grant: got %b want 0001", bus.o_grant); end
    hi = bus.o_start ? 1 : 0;
    for (int t = 0; t < 100 && bus.o_start; t++) begin
      tick();
      if (bus.o_start) hi++;
    end
    n_chk++; if (hi != 64) begin n_fail++; $display("FAIL to_start_len: got %0d want 64", hi); end
    n_chk++; if (bus.o_err !== 4'b0001 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL to_err: got err %b busy %0h want 0001 1", bus.o_err, bus.o_busy); end
    idle_t = 0;
    for (int t = 0; t < 30 && bus.o_busy; t++) begin tick(); idle_t++; end
    n_chk++; if (bus.o_busy !== 1'b0 || idle_t < 12) begin n_fail++; $display("FAIL to_ipg: got busy %0h after %0d want 0 after >=12", bus.o_busy, idle_t); end
  endtask

  task automatic test_reset_mid_tx();
    bit found;
    bit bad;
    set_desc(2, 48'h2222_2222_2222, 16'h0806, 16'd20, 8'd5);
    bus.i_req = 4'b0100;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    bus.i_req = 4'b0;
    n_chk++; if (!found || bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL rst_tx_grant: got %b want 0100", bus.o_grant); end
    tick(); bus.i_tx_valid = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_chk++; if ({bus.o_start, bus.o_busy, bus.o_grant, bus.o_done, bus.o_err} !== 14'h0) begin n_fail++; $display("FAIL rst_tx_ctrl: got %0h want 0", {bus.o_start, bus.o_busy, bus.o_grant, bus.o_done, bus.o_err}); end
    n_chk++; if ({bus.o_dest_address, bus.o_eth_type, bus.o_payload_length, bus.o_interrupt} !== '0 || bus.o_src_address !== SRC) begin n_fail++; $display("FAIL rst_tx_desc: got %0h src %0h", bus.o_dest_address, bus.o_src_address); end
    bus.i_tx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (bus.o_done != 4'b0 || bus.o_err != 4'b0) bad = 1'b1;
    end
    n_chk++; if (bad) begin n_fail++; $display("FAIL rst_tx_nopulse: got pulse want none"); end
    bus.i_req = 4'b1111;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus.o_grant != 4'b0) found = 1'b1;
    end
    bus.i_req = 4'b0;
    n_chk++; if (!found || bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL rst_tx_first: got %b want 0001", bus.o_grant); end
    tick(); bus.i_tx_valid = 1'b1;
    tick(); tick();
    bus.i_tx_valid = 1'b0;
    for (int t = 0; t < 30 && bus.o_busy; t++) tick();
    n_chk++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_idle: got %0h want 0", bus.o_busy); end
  endtask

  initial begin
    test_reset();
`ifdef SCHED_STRICT_PRIO_EN
    test_strict();
`else
    test_rr();
`endif
    test_single();
    test_bad_len();
    test_timeout();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_tx_frame_scheduler.md
Name: mac_tx_frame_scheduler

Overview:
- Sequences frame transmissions into the MAC/MII frame generator (mac_mii_top) on behalf of NUM_REQ requesters.
- Arbitrates between requesters, then latches the winner's descriptor (dest, eth type, payload length, interrupt mode).
- Drives the generator's start/descriptor inputs and watches its o_txValid to detect frame start and end.
- Enforces a programmable inter-frame gap, and rejects bad descriptors or stalled frames with per-requester error pulses.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PAYLOAD_MAX_SIZE, 1500, largest legal payload length in bytes.
- IPG_CYCLES, 12, idle clocks enforced after a frame ends (>=1).
- START_TIMEOUT, 64, max clocks from o_start rising to i_tx_valid rising.
- SRC_ADDRESS, 48'h123456789ABC, station source MAC address driven on o_src_address.

Ports:
- clk  in  1  single system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_req  in  NUM_REQ  per-requester frame request, level.
- i_req_dest  in  NUM_REQ*48  per-requester destination address; requester k in bits [k*48 +: 48].
- i_req_eth_type  in  NUM_REQ*16  per-requester eth type.
- i_req_length  in  NUM_REQ*16  per-requester payload length.
- i_req_mode  in  NUM_REQ*8  per-requester interrupt/mode code; 8'd2 = NO_PADDING, passed through unchanged.
- i_tx_valid  in  1  generator o_txValid; high while a frame is on MII.
- o_start  out  1  to generator i_start.
- o_dest_address  out  48  latched descriptor.
- o_src_address  out  48  constant SRC_ADDRESS.
- o_eth_type  out  16  latched descriptor.
- o_payload_length  out  16  latched descriptor.
- o_interrupt  out  8  latched mode.
- o_grant  out  NUM_REQ  one-hot, 1-cycle pulse when a descriptor is accepted.
- o_done  out  NUM_REQ  one-hot, 1-cycle pulse when the frame completes.
- o_err  out  NUM_REQ  one-hot, 1-cycle pulse on rejection or timeout.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, except o_src_address = SRC_ADDRESS. State = IDLE. RR pointer = NUM_REQ-1, so requester 0 wins first. All counters cleared.
- Reset mid-frame: the next clk with i_rst_n=0 forces the reset values. o_start drops immediately. No done or err pulse is issued for the aborted frame.
- IDLE: if any i_req is high, go to ARB next cycle.
- ARB (1 cycle):
  - Round-robin: winner = first set i_req at index ptr+1, ptr+2, ... modulo NUM_REQ.
  - Latch the winner's descriptor and set ptr = winner.
  - If length == 0 or length > PAYLOAD_MAX_SIZE: pulse o_err[winner] and return to IDLE. The descriptor outputs keep their previous values and no start is issued.
  - Otherwise: pulse o_grant[winner] and go to START.
  - If i_req is all-zero in ARB (requester withdrew), return to IDLE with no pulse.
- START:
  - o_start = 1 and the timeout counter increments every cycle.
  - On i_tx_valid = 1, go to TX with o_start = 0 in that same registered update.
  - If the counter reaches START_TIMEOUT without i_tx_valid: pulse o_err[winner], drop o_start, go to IPG.
- TX: o_start = 0. On i_tx_valid falling (1 to 0), pulse o_done[winner] and go to IPG.
- IPG:
  - Count IPG_CYCLES clocks, then go to IDLE.
  - Requests are not sampled in IPG, so the minimum spacing between grants is IPG_CYCLES+3 clocks.
- Descriptor outputs are stable from the grant until the next accepted grant. Changes on i_req_* after the grant are ignored.
- A requester that keeps i_req high is re-served only after every other active requester has had a turn (RR fairness).
- Counter widths: $clog2(START_TIMEOUT+1) and $clog2(IPG_CYCLES+1). Length compare is unsigned 16-bit.

Optional Feature:
- Macro: SCHED_STRICT_PRIO_EN.
- Defined: ARB picks the lowest-index set i_req (strict priority) and the RR pointer is unused. Requester 0 can starve the others.
- Undefined: round-robin as specified above.

Test Plan:
- Single request, requester 1: i_req=4'b0010, len=49, mode=0, generator model raises tx_valid 3 clks after start and holds it 10 clks. Required: o_grant=0010; o_start high 3 clks; descriptor outputs match; o_done=0010 on the falling edge of tx_valid; next grant no earlier than 12 clks after done.
- RR fairness: i_req=4'b1111 held, length 8 on all. Required: grant order 0,1,2,3,0; exactly one o_done per grant.
- Bad length: requester 2 with len=0, then len=1501. Required: o_err=0100 each time; o_start never asserted; requester 3 with len=1500 is then granted normally.
- Start timeout: tx_valid tied 0, START_TIMEOUT=64. Required: o_start high exactly 64 clks; o_err pulse; o_busy returns to 0 after IPG.
- Reset mid-TX: assert i_rst_n=0 during TX. Required: next clk all outputs at reset values; no done pulse; requester 0 wins the first arbitration after release.
- With SCHED_STRICT_PRIO_EN: i_req=4'b1001 held. Required: requester 0 granted repeatedly; requester 3 never granted while bit 0 is set. Check mode=2 (NO_PADDING) appears on o_interrupt.
